// File: rtl/mem_rd_pkg.sv
// Shared constants, FSM state type and parity helper for the burst read engine.
package mem_rd_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    // Even parity: the stored bit makes the XOR over data and parity zero.
    function automatic logic parity_err(input logic [DATA_W-1:0] data, input logic parity);
        return (^data) != parity;
    endfunction

endpackage

// File: rtl/rd_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at any fill level.
module rd_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the head slot, so a full FIFO may still accept.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Credit-limited burst reader: issues sequential memory reads, checks parity on return
// and streams {data, perr, last} through an output FIFO.
module mem_burst_reader
    import mem_rd_pkg::*;
#(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_addr_en,
    output logic              mem_rd_en,
    output logic              mem_dout_en,
    output logic              mem_blk_sel,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_parity,
    output logic [DATA_W-1:0] m_data,
    output logic              m_perr,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W  = CNT_W + 1;
    localparam int unsigned FW    = DATA_W + 2;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d, issued_q, issued_d;
    logic [CR_W-1:0]     inflight_q, inflight_d;
    logic [RD_LAT-1:0]   tag_v_q, tag_v_d, tag_l_q, tag_l_d;
    logic [15:0]         err_q, err_d;
    logic                credit, issue, last_issue, push, pop, perr, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [FW-1:0]       fifo_rdata;

    // Every read holds one credit from issue until its word leaves the FIFO.
    assign credit     = (inflight_q + CR_W'(fifo_count)) < CR_W'(FIFO_DEPTH);
    assign issue      = (state_q == ISSUE) && credit;
    assign last_issue = (issued_q + (ADDR_W + 1)'(1)) == len_q;
    assign push       = tag_v_q[RD_LAT-1];
    assign perr       = parity_err(mem_dout, mem_parity);
    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        err_d      = err_q;
        inflight_d = inflight_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = len;
                    issued_d = '0;
                    err_d    = '0;
                    state_d  = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + (ADDR_W + 1)'(1);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the final word is popped so done lands one cycle after it.
                if (inflight_q == '0 && (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue && !push) begin
            inflight_d = inflight_q + CR_W'(1);
        end else if (push && !issue) begin
            inflight_d = inflight_q - CR_W'(1);
        end
        if (push && perr && err_q != '1) begin
            err_d = err_q + 16'd1;
        end
        tag_v_d[0] = issue;
        tag_l_d[0] = last_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_l_d[i] = tag_l_q[i-1];
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            tag_v_q    <= '0;
            tag_l_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            tag_v_q    <= tag_v_d;
            tag_l_q    <= tag_l_d;
            err_q      <= err_d;
        end
    end

    rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk1),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i ({mem_dout, perr, tag_l_q[RD_LAT-1]}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err_cnt     = err_q;
    assign mem_addr    = addr_q;
    assign mem_addr_en = issue;
    assign mem_rd_en   = issue;
    assign mem_dout_en = issue;
    assign mem_blk_sel = issue;
    assign mem_wr_en   = 1'b0;
    // Stream fields read zero when nothing is presented.
    assign m_data      = m_valid ? fifo_rdata[FW-1:2] : '0;
    assign m_perr      = m_valid && fifo_rdata[1];
    assign m_last      = m_valid && fifo_rdata[0];

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Burst read engine that sits directly downstream of the 1024x16 parity-protected block memory. It accepts a start/base/length command, issues sequential read cycles to the memory's control pins, and captures each returned word with its parity bit. It checks parity and delivers the words on a valid/ready stream with per-word error and last flags. A credit scheme bounds in-flight reads, so stream backpressure never loses data.

## Interface
Parameters:
- ADDR_W, 10, memory address width (1024 words).
- DATA_W, 16, memory data width.
- RD_LAT, 2, cycles from issue (address/enables presented) to mem_dout/mem_parity valid.
- FIFO_DEPTH, 4, output buffer depth; must be ≥ RD_LAT+1 for one word/cycle throughput.

Ports:
- clk1  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- base_addr  in  ADDR_W  first word address, sampled on accepted start.
- len  in  ADDR_W+1  word count 0..1024, sampled on accepted start.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last word is consumed.
- err_cnt  out  16  saturating count of parity errors in the current burst.
- mem_addr  out  ADDR_W  read address.
- mem_addr_en, mem_rd_en, mem_dout_en, mem_blk_sel  out  1 each  asserted together on issue cycles only.
- mem_wr_en  out  1  constant 0.
- mem_dout  in  DATA_W  read data from memory.
- mem_parity  in  1  parity bit from memory.
- m_data  out  DATA_W  stream data.
- m_perr  out  1  parity mismatch for this word.
- m_last  out  1  final word of burst.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE to ISSUE on start with len≠0. Base and len are latched, err_cnt is cleared, and busy rises the next cycle.
- IDLE to DONE on start with len=0. No memory access occurs, and done pulses on the next cycle.
- ISSUE: one read is issued per cycle while credit allows; credit = inflight + fifo_count < FIFO_DEPTH. mem_addr increments by 1 mod 1024 after each issue (1023 wraps to 0). The state moves to DRAIN when the issued count reaches len.
- DRAIN: waits until inflight=0 and the FIFO is empty, then goes to DONE.
- DONE: asserts done for 1 cycle, then returns to IDLE. busy drops in the cycle after DONE.
- Return path: an RD_LAT-deep tag shift register carries {valid, last}. When a tagged word returns, the FIFO pushes {mem_dout, perr, last}, where perr = (^mem_dout) != mem_parity (even parity).
- err_cnt increments by 1 on each push with perr=1 and saturates at 0xFFFF.
- A simultaneous FIFO push and pop is allowed at any occupancy. By construction of the credit scheme, a push never occurs when the FIFO is full.
- Stream output: m_valid = FIFO non-empty. Head fields are stable while m_valid=1 and m_ready=0.
- Reset at any time returns the FSM to IDLE and discards the FIFO and in-flight tags. err_cnt is cleared.

## Timing
- Reset values: busy, done, mem_* enables, mem_addr, m_valid, m_perr, m_last, m_data, err_cnt all 0.
- Issue cycle t: mem_addr and enables are driven from registers during cycle t. The word is pushed at the edge ending cycle t+RD_LAT and is visible on m_data in cycle t+RD_LAT+1.
- First-word latency: the first issue occurs in the cycle after start. m_valid rises RD_LAT+2 cycles after the start cycle.
- With m_ready held at 1, the burst sustains 1 word/cycle. done pulses 1 cycle after the handshake on the word with m_last.
- With m_ready held at 0, at most FIFO_DEPTH reads are outstanding and issue stalls. Issue resumes the cycle after a pop frees credit.

## Structure
- Package mem_rd_pkg holds ADDR_W, DATA_W, and the state enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module rd_fifo: synchronous FIFO, width DATA_W+2, depth FIFO_DEPTH, with count output, async active-high reset.
- Top level holds the FSM, address/issued counters, inflight counter, tag shift register, parity check, and err_cnt.

## Test plan
- Memory preloaded mem[i]=i with correct parity; start with base=0x010, len=8, m_ready=1 → data 0x0010..0x0017, m_last on 0x0017, m_perr=0, done 1 cycle after the last handshake, err_cnt=0.
- base=0x3FE, len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; data follows the wrap.
- len=8 with m_ready=0 for 20 cycles, then 1 → exactly FIFO_DEPTH issues before the stall; all 8 words delivered in order with none lost or duplicated.
- Parity of words 2 and 5 corrupted in the model, len=8 → m_perr=1 on exactly those two words; err_cnt=2 at done.
- len=0 → no mem_rd_en; done pulses the cycle after start. start held high during a burst is ignored.
- rst asserted mid-burst with 3 words in flight → all outputs 0 immediately; the next start for len=2 returns exactly 2 fresh words.
